pdp8l_i2c_target: RTL and testbench
===================================

# pdp8l_i2c_target

I2C target (responder) for the PDP-8/L front panel bus: the other end of the Zynq-side I2C master. It decodes START/STOP, matches a 7-bit device address, and exposes a byte-wide register file through a simple strobe interface. Typical uses are emulating a front-panel I/O-expander in simulation, and an FPGA-resident loopback target for bring-up of the master and its software driver.

## Interface
- DEVADDR, 7'h20, 7-bit I2C address this target answers to.
- PTRW, 4, register-pointer width; register space is 2^PTRW bytes.
- CLOCK  in  1  system clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- i2cclk  in  1  SCL as seen on the bus (wired-AND already resolved).
- i2cdai  in  1  SDA as seen on the bus.
- i2cdao  out  1  SDA drive: 0 = pull low, 1 = release.
- regaddr  out  PTRW  current register pointer; also the read address.
- rddata  in  8  register contents at regaddr, combinational from the user side.
- wrstb  out  1  one-cycle pulse; write wrdata to register regaddr.
- wrdata  out  8  write data, valid while wrstb = 1.
- selected  out  1  high from address match until STOP, repeated START, or NACK.

## Operation
- Inputs pass through a 2-flop synchronizer. Edges are detected on the synchronized copies.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Bits are sampled on the SCL rising edge. i2cdao changes only on the SCL falling edge, except on STOP, START, and RESET, which release it immediately.
- States:
  - IDLE
  - ADDR: shift 8 bits.
  - ADDRACK
  - PTR: receive the pointer byte.
  - PTRACK
  - WDATA
  - WACK
  - RDATA: drive 8 bits, MSB first.
  - RACK: sample the master's ACK.
  - IGNORE
- START from any state: go to ADDR and clear the bit counter.
- STOP from any state: go to IDLE, release i2cdao, drop `selected`.
- ADDR complete:
  - Address ≠ DEVADDR: go to IGNORE (no ACK) until the next START or STOP.
  - Match, R/W = 0: drive ACK, then go to PTR.
  - Match, R/W = 1: drive ACK, then go to RDATA.
- PTR complete: load regaddr with byte[PTRW-1:0] and ACK. Upper bits are ignored. Following bytes go to WDATA.
- WDATA complete: wrdata = byte; wrstb pulses; ACK. regaddr increments on the cycle after wrstb and wraps from 2^PTRW-1 to 0.
- RDATA:
  - rddata is latched into the shift register on the SCL falling edge that ends the preceding ACK.
  - After the 8th bit, release SDA and sample the master's bit on the 9th rising edge.
  - ACK (0): increment regaddr; the next falling edge loads the new rddata.
  - NACK (1): go to IGNORE and drop `selected`. regaddr is still incremented.
- regaddr persists across transactions, so a write of only the pointer followed by a repeated START and a read gives the standard register-read sequence.
- A general call (address 0) is never ACKed.

## Timing
- Reset values:
  - i2cdao = 1
  - wrstb = 0
  - selected = 0
  - regaddr = 0
  - wrdata = 0
  - state = IDLE
- Input latency: 2 CLOCK cycles of synchronizer plus 1 cycle of edge detect. Every bus action lands 3 cycles after the pin edge.
- CLOCK must be at least 8× the SCL rate, so that 3 cycles fit well inside the SCL low-phase data-setup time.
- ACK drive: i2cdao = 0 from 3 cycles after the 8th SCL falling edge until 3 cycles after the 9th falling edge.
- wrstb: asserted for exactly 1 cycle, coincident with the start of WACK ACK drive.
- Read data: the rddata combinational path from regaddr has one full CLOCK cycle to settle. regaddr changes at least 1 cycle before the falling edge that latches rddata.
- START and STOP detected in the same cycle as an SCL edge: START/STOP wins and no bit is shifted.
- RESET mid-transfer: i2cdao released on the next cycle, state = IDLE, and any pending wrstb is suppressed.

## Structure
- Shared package (`pdp8l_i2c_pkg`) holds:
  - the state enum;
  - localparams for the bit count (8) and the ACK bit index (9);
  - the edge-detect encoding, shared with the master's testbench.
- One sub-module, `i2c_bus_sync`: the 2-flop synchronizer plus SCL rise/fall and START/STOP detection. It outputs single-cycle pulses sclrise, sclfall, start, stop, and the synchronized sda.
- The register file is outside this block.

## Test plan
- Address match: START, 0x40 (address 0x20, write), 0x05, 0xA5, STOP.
  - ACK after both bytes.
  - wrstb pulses once with regaddr = 5, wrdata = 0xA5.
  - regaddr = 6 afterwards.
- Wrong address: START, 0x42, … → i2cdao stays 1 for the entire transfer; wrstb never asserts; selected = 0.
- Burst write with wrap: pointer 0x0F, then data 0x11, 0x22 → writes 0x11 to reg 15 and 0x22 to reg 0; regaddr = 1.
- Pointer-then-read:
  - Sequence: write pointer 3, repeated START, 0x41, master ACKs one byte, NACKs the second.
  - rddata model reg[n] = 0x30+n.
  - Bus returns 0x33 then 0x34; selected drops on the NACK.
- Mid-byte interruption:
  - STOP after 4 data bits → no wrstb; i2cdao = 1; state IDLE.
  - START mid-byte → fresh address phase is ACKed correctly.
- RESET asserted while driving ACK → i2cdao = 1 on the next cycle; the next transaction behaves as from power-up with regaddr = 0.

Source files
------------

// File: rtl/pdp8l_i2c_pkg.sv
// Shared types and constants for the PDP-8/L front-panel I2C target.
package pdp8l_i2c_pkg;

  // Data bits per byte and the position of the ACK slot in the 9-bit frame.
  localparam logic [3:0] I2C_NBITS  = 4'd8;
  localparam logic [3:0] I2C_ACKBIT = 4'd9;

  // The bit counter is loaded with I2C_ACKBIT at the start of each byte and
  // decremented on every SCL rise; reaching this value means only the ACK
  // slot of the frame remains.
  localparam logic [3:0] I2C_TC = I2C_ACKBIT - I2C_NBITS;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDRACK,
    PTR,
    PTRACK,
    WDATA,
    WACK,
    RDATA,
    RACK,
    IGNORE
  } i2c_state_t;

  // Single-cycle bus events produced by the synchronizer/edge detector.
  typedef struct packed {
    logic start;
    logic stop;
    logic sclrise;
    logic sclfall;
  } i2c_ev_t;

endpackage

// File: rtl/pdp8l_i2c_bus_sync.sv
// Two-flop synchronizer for SCL/SDA plus edge, START and STOP detection.
// Event outputs are single-cycle pulses derived from the synchronized copies.
module i2c_bus_sync (
  input  logic CLOCK,
  input  logic RESET,
  input  logic i2cclk,
  input  logic i2cdai,
  output logic sclrise,
  output logic sclfall,
  output logic start,
  output logic stop,
  output logic sda
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_d;
  logic       sda_d;

  // Synchronize both bus lines and keep one cycle of history for edge detect.
  // Reset to the idle-bus level so no spurious edge appears on release.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], i2cclk};
      sda_sync <= {sda_sync[0], i2cdai};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign sda     = sda_sync[1];
  assign sclrise =  scl_sync[1] & ~scl_d;
  assign sclfall = ~scl_sync[1] &  scl_d;
  // SDA transitions while SCL is high are bus conditions, not data.
  assign start   =  scl_sync[1] &  sda_d & ~sda_sync[1];
  assign stop    =  scl_sync[1] & ~sda_d &  sda_sync[1];

endmodule

// File: rtl/pdp8l_i2c_target.sv
// I2C target for the PDP-8/L front-panel bus: address match, register
// pointer, burst write and burst read over a byte-wide strobe interface.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | bus free or after STOP; waiting for START
// ADDR    | shifting in the 7-bit address and R/W bit
// ADDRACK | driving ACK for a matched address
// PTR     | shifting in the register-pointer byte
// PTRACK  | driving ACK for the pointer byte
// WDATA   | shifting in a write-data byte
// WACK    | driving ACK for a write-data byte (wrstb fires on entry)
// RDATA   | driving a read byte MSB first
// RACK    | SDA released, sampling the master's ACK/NACK
// IGNORE  | not addressed or read ended by NACK; wait for START/STOP
module pdp8l_i2c_target
  import pdp8l_i2c_pkg::*;
#(
  parameter logic [6:0] DEVADDR = 7'h20,
  parameter int         PTRW    = 4
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            i2cclk,
  input  logic            i2cdai,
  output logic            i2cdao,
  output logic [PTRW-1:0] regaddr,
  input  logic [7:0]      rddata,
  output logic            wrstb,
  output logic [7:0]      wrdata,
  output logic            selected
);

  i2c_ev_t    ev;
  logic       ev_start;
  logic       ev_stop;
  logic       ev_rise;
  logic       ev_fall;
  logic       sda;

  i2c_state_t      state, state_nxt;
  logic [3:0]      bitcnt, bitcnt_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic            rw, rw_nxt;
  logic            dao_nxt;
  logic            selected_nxt;
  logic            wrstb_nxt;
  logic [PTRW-1:0] regaddr_nxt;
  logic [7:0]      wrdata_nxt;
  logic            addr_hit;

  i2c_bus_sync u_sync (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .i2cclk  (i2cclk),
    .i2cdai  (i2cdai),
    .sclrise (ev_rise),
    .sclfall (ev_fall),
    .start   (ev_start),
    .stop    (ev_stop),
    .sda     (sda)
  );

  assign ev = '{start: ev_start, stop: ev_stop, sclrise: ev_rise, sclfall: ev_fall};

  // The general-call address is never claimed, even if DEVADDR were 0.
  assign addr_hit = (shreg[7:1] == DEVADDR) && (shreg[7:1] != 7'd0);

  // State and datapath registers.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= IDLE;
      bitcnt   <= I2C_ACKBIT;
      shreg    <= 8'h00;
      rw       <= 1'b0;
      i2cdao   <= 1'b1;
      selected <= 1'b0;
      regaddr  <= '0;
      wrdata   <= 8'h00;
      wrstb    <= 1'b0;
    end else begin
      state    <= state_nxt;
      bitcnt   <= bitcnt_nxt;
      shreg    <= shreg_nxt;
      rw       <= rw_nxt;
      i2cdao   <= dao_nxt;
      selected <= selected_nxt;
      regaddr  <= regaddr_nxt;
      wrdata   <= wrdata_nxt;
      wrstb    <= wrstb_nxt;
    end
  end

  // Next-state and output logic; START/STOP take priority over SCL edges.
  always_comb begin
    state_nxt    = state;
    bitcnt_nxt   = bitcnt;
    shreg_nxt    = shreg;
    rw_nxt       = rw;
    dao_nxt      = i2cdao;
    selected_nxt = selected;
    regaddr_nxt  = regaddr;
    wrdata_nxt   = wrdata;
    wrstb_nxt    = 1'b0;

    // Post-write increment lands the cycle after the strobe.
    if (wrstb) regaddr_nxt = regaddr + PTRW'(1);

    if (ev.stop) begin
      state_nxt    = IDLE;
      dao_nxt      = 1'b1;
      selected_nxt = 1'b0;
    end else if (ev.start) begin
      state_nxt    = ADDR;
      bitcnt_nxt   = I2C_ACKBIT;
      dao_nxt      = 1'b1;
      selected_nxt = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (ev.sclrise && bitcnt != I2C_TC) begin
            shreg_nxt  = {shreg[6:0], sda};
            bitcnt_nxt = bitcnt - 4'd1;
          end else if (ev.sclfall && bitcnt == I2C_TC) begin
            dao_nxt = 1'b0;
            case (state)
              ADDR: begin
                if (addr_hit) begin
                  state_nxt    = ADDRACK;
                  rw_nxt       = shreg[0];
                  selected_nxt = 1'b1;
                end else begin
                  state_nxt = IGNORE;
                  dao_nxt   = 1'b1;
                end
              end
              PTR: begin
                regaddr_nxt = shreg[PTRW-1:0];
                state_nxt   = PTRACK;
              end
              default: begin
                wrdata_nxt = shreg;
                wrstb_nxt  = 1'b1;
                state_nxt  = WACK;
              end
            endcase
          end
        end
        ADDRACK: begin
          if (ev.sclfall) begin
            bitcnt_nxt = I2C_ACKBIT;
            if (rw) begin
              state_nxt = RDATA;
              shreg_nxt = rddata;
              dao_nxt   = rddata[7];
            end else begin
              state_nxt = PTR;
              dao_nxt   = 1'b1;
            end
          end
        end
        PTRACK, WACK: begin
          if (ev.sclfall) begin
            state_nxt  = WDATA;
            bitcnt_nxt = I2C_ACKBIT;
            dao_nxt    = 1'b1;
          end
        end
        RDATA: begin
          if (ev.sclrise && bitcnt != I2C_TC) begin
            bitcnt_nxt = bitcnt - 4'd1;
          end else if (ev.sclfall) begin
            if (bitcnt == I2C_TC) begin
              state_nxt = RACK;
              dao_nxt   = 1'b1;
            end else begin
              shreg_nxt = {shreg[6:0], 1'b0};
              dao_nxt   = shreg[6];
            end
          end
        end
        RACK: begin
          // Pointer advances on ACK and NACK alike, ahead of the next load.
          if (ev.sclrise) begin
            regaddr_nxt = regaddr + PTRW'(1);
            if (sda) begin
              state_nxt    = IGNORE;
              selected_nxt = 1'b0;
            end
          end else if (ev.sclfall) begin
            state_nxt  = RDATA;
            shreg_nxt  = rddata;
            dao_nxt    = rddata[7];
            bitcnt_nxt = I2C_ACKBIT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pdp8l_i2c_target.sv
// Bench for pdp8l_i2c_target: bit-banged I2C master, user-side register
// file, and a byte-level reference model of the register space and pointer.
module tb_pdp8l_i2c_target;
  import pdp8l_i2c_pkg::*;

  localparam int Q = 4;   // CLOCK cycles per quarter SCL period

  logic       CLOCK  = 1'b0;
  logic       RESET  = 1'b1;
  logic       i2cclk = 1'b1;
  logic       m_sda  = 1'b1;
  logic       i2cdai;
  logic       i2cdao;
  logic [3:0] regaddr;
  logic [7:0] rddata;
  logic       wrstb;
  logic [7:0] wrdata;
  logic       selected;

  logic [7:0] mem [16];
  logic [3:0] wq_a [$];
  logic [7:0] wq_d [$];
  int         dao_low = 0;

  logic [7:0] exp_mem [16];
  int         exp_ptr;
  logic [7:0] wbuf [4];
  int         n_total = 0;
  int         n_pass  = 0;

  pdp8l_i2c_target #(.DEVADDR(7'h20), .PTRW(4)) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .i2cclk   (i2cclk),
    .i2cdai   (i2cdai),
    .i2cdao   (i2cdao),
    .regaddr  (regaddr),
    .rddata   (rddata),
    .wrstb    (wrstb),
    .wrdata   (wrdata),
    .selected (selected)
  );

  always #5 CLOCK = ~CLOCK;

  assign i2cdai = m_sda & i2cdao;
  assign rddata = mem[regaddr];

  // User-side register file, reset to reg[n] = 0x30 + n.
  always @(posedge CLOCK) begin
    if (RESET) for (int n = 0; n < 16; n++) mem[n] <= 8'h30 + 8'(n);
    else if (wrstb) mem[regaddr] <= wrdata;
  end

  // Log write strobes and count cycles with SDA pulled low by the target.
  always @(negedge CLOCK) begin
    if (wrstb) begin
      wq_a.push_back(regaddr);
      wq_d.push_back(wrdata);
    end
    if (!i2cdao) dao_low++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic init_model();
    for (int n = 0; n < 16; n++) exp_mem[n] = 8'h30 + 8'(n);
    exp_ptr = 0;
  endtask

  task automatic bit_xfer(input logic b, output logic rb);
    m_sda = b;  tick(Q);
    i2cclk = 1'b1; tick(Q);
    rb = i2cdai; tick(Q);
    i2cclk = 1'b0; tick(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;  tick(Q);
    i2cclk = 1'b1; tick(Q);
    m_sda = 1'b0;  tick(Q);
    i2cclk = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;  tick(Q);
    i2cclk = 1'b1; tick(Q);
    m_sda = 1'b1;  tick(Q);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic x;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], x);
    bit_xfer(1'b1, ack);
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] d);
    logic x;
    for (int i = 7; i >= 0; i--) bit_xfer(1'b1, d[i]);
    bit_xfer(mack, x);
  endtask

  // Pointer write followed by n data bytes from wbuf, checked against the model.
  task automatic do_write(input logic [7:0] ptr, input int n);
    int   base;
    logic ack;
    base = wq_a.size();
    i2c_start();
    wbyte(8'h40, ack);   chk("wr addr ack", ack, 1'b0);
    chk("wr selected", selected, 1'b1);
    wbyte(ptr, ack);     chk("wr ptr ack", ack, 1'b0);
    exp_ptr = int'(ptr) % 16;
    for (int i = 0; i < n; i++) begin
      wbyte(wbuf[i], ack); chk("wr data ack", ack, 1'b0);
    end
    i2c_stop();
    chk("wr strobe count", wq_a.size() - base, n);
    if (wq_a.size() == base + n) begin
      for (int i = 0; i < n; i++) begin
        chk("wr strobe addr", wq_a[base+i], exp_ptr);
        chk("wr strobe data", wq_d[base+i], wbuf[i]);
        exp_mem[exp_ptr] = wbuf[i];
        exp_ptr = (exp_ptr + 1) % 16;
      end
    end
    chk("wr regaddr after", regaddr, exp_ptr);
    chk("wr sda released", i2cdao, 1'b1);
    chk("wr deselected", selected, 1'b0);
  endtask

  // Optional pointer write + repeated START, then n bytes read, last NACKed.
  task automatic do_read(input int n, input logic setptr, input logic [7:0] ptr);
    logic       ack;
    logic [7:0] d;
    i2c_start();
    if (setptr) begin
      wbyte(8'h40, ack); chk("rd ptr addr ack", ack, 1'b0);
      wbyte(ptr, ack);   chk("rd ptr ack", ack, 1'b0);
      exp_ptr = int'(ptr) % 16;
      i2c_start();
    end
    wbyte(8'h41, ack);   chk("rd addr ack", ack, 1'b0);
    chk("rd selected", selected, 1'b1);
    for (int i = 0; i < n; i++) begin
      rbyte(i == n - 1, d);
      chk("rd data", d, exp_mem[exp_ptr]);
      exp_ptr = (exp_ptr + 1) % 16;
    end
    chk("rd selected after nack", selected, 1'b0);
    i2c_stop();
    chk("rd regaddr after", regaddr, exp_ptr);
  endtask

  initial begin
    logic ack;
    logic x;
    logic [7:0] d;
    int base;
    int low0;
    int sel;

    // Power-up reset
    init_model();
    tick(5);
    RESET = 1'b0;
    tick(2);
    chk("reset i2cdao", i2cdao, 1'b1);
    chk("reset wrstb", wrstb, 1'b0);
    chk("reset selected", selected, 1'b0);
    chk("reset regaddr", regaddr, 4'd0);
    chk("reset wrdata", wrdata, 8'h00);
    chk("reset state", 32'(dut.state), 32'(IDLE));

    // Address match: pointer 5, data 0xA5
    wbuf[0] = 8'hA5;
    do_write(8'h05, 1);

    // Wrong address and general call: never ACKed, no strobe, not selected
    base = wq_a.size();
    low0 = dao_low;
    i2c_start();
    wbyte(8'h42, ack);  chk("wrong addr nack", ack, 1'b1);
    chk("wrong addr selected", selected, 1'b0);
    wbyte(8'h12, ack);  chk("wrong addr data nack", ack, 1'b1);
    i2c_stop();
    i2c_start();
    wbyte(8'h00, ack);  chk("general call nack", ack, 1'b1);
    i2c_stop();
    chk("wrong addr sda never low", dao_low - low0, 0);
    chk("wrong addr no strobe", wq_a.size() - base, 0);

    // Burst write wrapping 15 -> 0
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    do_write(8'h0F, 2);

    // Pointer-then-read: 0x33, 0x34
    do_read(2, 1'b1, 8'h03);

    // STOP after 4 data bits
    base = wq_a.size();
    i2c_start();
    wbyte(8'h40, ack);  chk("midstop addr ack", ack, 1'b0);
    wbyte(8'h07, ack);  chk("midstop ptr ack", ack, 1'b0);
    exp_ptr = 7;
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, x);
    i2c_stop();
    chk("midstop no strobe", wq_a.size() - base, 0);
    chk("midstop i2cdao", i2cdao, 1'b1);
    chk("midstop state", 32'(dut.state), 32'(IDLE));
    chk("midstop regaddr", regaddr, exp_ptr);

    // Repeated START mid-byte, fresh address phase
    i2c_start();
    wbyte(8'h40, ack);  chk("midstart addr ack", ack, 1'b0);
    wbyte(8'h02, ack);  chk("midstart ptr ack", ack, 1'b0);
    exp_ptr = 2;
    for (int i = 0; i < 3; i++) bit_xfer(1'b0, x);
    i2c_start();
    wbyte(8'h40, ack);  chk("midstart readdr ack", ack, 1'b0);
    chk("midstart selected", selected, 1'b1);
    i2c_stop();
    chk("midstart no strobe", wq_a.size() - base, 0);
    chk("midstart regaddr", regaddr, exp_ptr);

    // RESET while the target drives the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_xfer(((8'h40 >> i) & 8'h01) != 8'h00, x);
    m_sda = 1'b1;
    tick(Q);
    chk("ack driven before reset", i2cdao, 1'b0);
    RESET = 1'b1;
    tick(1);
    chk("reset mid-ack i2cdao", i2cdao, 1'b1);
    chk("reset mid-ack regaddr", regaddr, 4'd0);
    chk("reset mid-ack selected", selected, 1'b0);
    tick(2);
    RESET = 1'b0;
    init_model();
    tick(Q);
    i2c_stop();
    do_read(1, 1'b0, 8'h00);

    // Randomized transactions against the model
    for (int it = 0; it < 10; it++) begin
      sel = $urandom_range(0, 2);
      if (sel == 0) begin
        d = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom_range(0, 255));
        do_write(d, $urandom_range(1, 3));
      end else if (sel == 1) begin
        d = 8'($urandom_range(0, 255));
        do_read($urandom_range(1, 3), 1'b1, d);
      end else begin
        do_read($urandom_range(1, 2), 1'b0, 8'h00);
      end
    end

    tick(4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
